spike_somatic_aggregator: RTL and testbench

//  Parametrised ascending-path aggregator for the Kitten Fabric bridge. Counts NoC-ejected spike flits per mesh

---
 rtl/kf_pkg.sv | 28 ++
 rtl/somatic_bank.sv | 58 +++++
 rtl/spike_somatic_aggregator.sv | 195 +++++++++++++++++++
 tb/tb_spike_somatic_aggregator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Kitten Fabric shared types used by the spike ascending path.
package kf_pkg;

  localparam int KF_COORD_W        = 4;
  localparam int KF_GAIN_FRAC_BITS = 8;
  localparam int KF_WORD_W         = 32;

  // Ejected spike flit; the aggregator only needs the destination tile.
  typedef struct packed {
    logic [KF_COORD_W-1:0] dest_y;
    logic [KF_COORD_W-1:0] dest_x;
  } spike_flit_t;

  typedef logic [KF_WORD_W-1:0] somatic_word_t;

  typedef enum logic {
    AGG_IDLE = 1'b0,
    AGG_SEND = 1'b1
  } agg_state_t;

  // Row-major region index of a tile within the mesh.
  function automatic int region_of(input logic [KF_COORD_W-1:0] dest_x,
                                   input logic [KF_COORD_W-1:0] dest_y,
                                   input int                    mesh_width);
    return int'(dest_y) * mesh_width + int'(dest_x);
  endfunction

endpackage

// File: rtl/somatic_bank.sv
// One bank of per-region saturating spike counters with a beat-wide read port.
module somatic_bank #(
  parameter int NUM_REGIONS = 16,
  parameter int COUNT_W     = 16,
  parameter int LANES       = 8,
  parameter int BEAT_W      = 1,
  parameter int REG_W       = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            inc,
  input  logic [REG_W-1:0]                inc_region,
  input  logic [BEAT_W-1:0]               rd_beat,
  output logic [LANES-1:0][COUNT_W-1:0]   rd_counts,
  output logic                            sat_hit
);

  logic [NUM_REGIONS-1:0][COUNT_W-1:0] cnt_flat;
  logic [NUM_REGIONS-1:0]              sat_vec;

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_reg
    logic [COUNT_W-1:0] cnt;
    logic               hit;

    assign hit = inc && (inc_region == REG_W'(r));

    // Saturating counter; a clear that coincides with a hit restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= hit ? COUNT_W'(1) : '0;
      end else if (hit && (cnt != '1)) begin
        cnt <= cnt + COUNT_W'(1);
      end
    end

    assign cnt_flat[r] = cnt;
    assign sat_vec[r]  = hit && !clr && (cnt == '1);
  end

  assign sat_hit = |sat_vec;

  // Each lane picks its region for the requested beat; padding lanes read zero.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [COUNT_W-1:0] cand [2**BEAT_W];
    for (genvar b = 0; b < 2**BEAT_W; b++) begin : g_beat
      if (b * LANES + l < NUM_REGIONS) begin : g_live
        assign cand[b] = cnt_flat[b * LANES + l];
      end else begin : g_pad
        assign cand[b] = '0;
      end
    end
    assign rd_counts[l] = cand[rd_beat];
  end

endmodule

// File: rtl/spike_somatic_aggregator.sv
// Ping-pong spike aggregator: counts ejected flits per mesh region and streams
// the gain-scaled frozen bank as an AXI-Stream somatic vector.
//
//   state | meaning
//   IDLE  | counting only, waiting for window expiry or snapshot request
//   SEND  | streaming frozen bank, one beat per handshake
module spike_somatic_aggregator
  import kf_pkg::*;
#(
  parameter int MESH_WIDTH  = 4,
  parameter int MESH_HEIGHT = 4,
  parameter int COUNT_W     = 16,
  parameter int OUT_W       = 512,
  parameter int WINDOW_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                eject_valid,
  output logic                eject_ready,
  input  spike_flit_t         eject_flit,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] window_cycles,
  input  logic                snap_req,
  input  logic [15:0]         gain,
  input  logic                clr_sticky,
  output logic                busy,
  output logic                overrun,
  output logic                sat,
  output logic [15:0]         drop_count
);

  localparam int NUM_REGIONS = MESH_WIDTH * MESH_HEIGHT;
  localparam int LANES       = OUT_W / 32;
  localparam int NUM_BEATS   = (NUM_REGIONS + LANES - 1) / LANES;
  localparam int BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  agg_state_t state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, load_beat;
  logic                load, finish;
  logic [WINDOW_W-1:0] timer_q;
  logic                timer_run, timer_hit, trigger, accept, overrun_set;
  logic                act_q, tgt_bank, rd_sel;
  logic                in_range, count_hit, drop_hit;
  logic [REG_W-1:0]    region;
  logic                sat_hit0, sat_hit1;
  logic [LANES-1:0][COUNT_W-1:0] counts0, counts1, counts_sel;
  somatic_word_t [LANES-1:0]     beat_data;

  assign eject_ready = 1'b1;
  assign busy        = (state_q == AGG_SEND);

  assign in_range  = (int'(eject_flit.dest_x) < MESH_WIDTH) && (int'(eject_flit.dest_y) < MESH_HEIGHT);
  assign count_hit = eject_valid && enable && in_range;
  assign drop_hit  = eject_valid && enable && !in_range;
  assign region    = REG_W'(region_of(eject_flit.dest_x, eject_flit.dest_y, MESH_WIDTH));

  assign timer_run   = enable && (window_cycles != '0);
  assign timer_hit   = timer_run && (timer_q == window_cycles - WINDOW_W'(1));
  assign trigger     = timer_hit || snap_req;
  assign accept      = trigger && (state_q == AGG_IDLE);
  assign overrun_set = trigger && (state_q == AGG_SEND);

  // On an accepted trigger the flit of that cycle already lands in the new bank.
  assign tgt_bank = accept ? ~act_q : act_q;
  // The bank about to freeze is still "active" in the accept cycle itself.
  assign rd_sel   = (state_q == AGG_IDLE) ? act_q : ~act_q;

  somatic_bank #(
    .NUM_REGIONS(NUM_REGIONS), .COUNT_W(COUNT_W), .LANES(LANES), .BEAT_W(BEAT_W), .REG_W(REG_W)
  ) u_bank0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept && act_q),
    .inc        (count_hit && !tgt_bank),
    .inc_region (region),
    .rd_beat    (load_beat),
    .rd_counts  (counts0),
    .sat_hit    (sat_hit0)
  );

  somatic_bank #(
    .NUM_REGIONS(NUM_REGIONS), .COUNT_W(COUNT_W), .LANES(LANES), .BEAT_W(BEAT_W), .REG_W(REG_W)
  ) u_bank1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept && !act_q),
    .inc        (count_hit && tgt_bank),
    .inc_region (region),
    .rd_beat    (load_beat),
    .rd_counts  (counts1),
    .sat_hit    (sat_hit1)
  );

  assign counts_sel = rd_sel ? counts1 : counts0;

  // Gain scaling: truncating UQ8.8 multiply, clamped to the 32-bit lane.
  for (genvar l = 0; l < LANES; l++) begin : g_scale
    logic [63:0] prod, shf;
    assign prod         = 64'(counts_sel[l]) * 64'(gain);
    assign shf          = prod >> KF_GAIN_FRAC_BITS;
    assign beat_data[l] = (|shf[63:32]) ? 32'hFFFF_FFFF : shf[31:0];
  end

  // Next-state and beat-load decisions.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_beat = '0;
    finish    = 1'b0;
    case (state_q)
      AGG_IDLE: begin
        if (trigger) begin
          state_d = AGG_SEND;
          load    = 1'b1;
        end
      end
      AGG_SEND: begin
        if (m_axis_tready) begin
          if (beat_q == LAST_BEAT) begin
            finish  = 1'b1;
            state_d = AGG_IDLE;
          end else begin
            load      = 1'b1;
            load_beat = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = AGG_IDLE;
    endcase
  end

  // State, beat index and registered AXI-Stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= AGG_IDLE;
      beat_q        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        beat_q        <= load_beat;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (load_beat == LAST_BEAT);
        m_axis_tdata  <= beat_data;
      end else if (finish) begin
        beat_q        <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tdata  <= '0;
      end
    end
  end

  // Window timer and active-bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      act_q   <= 1'b0;
    end else begin
      if (timer_run) timer_q <= timer_hit ? '0 : timer_q + WINDOW_W'(1);
      if (accept)    act_q   <= ~act_q;
    end
  end

  // Sticky status; a set event in the clearing cycle still takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      sat        <= 1'b0;
      drop_count <= '0;
    end else begin
      if (overrun_set)     overrun <= 1'b1;
      else if (clr_sticky) overrun <= 1'b0;

      if (sat_hit0 || sat_hit1) sat <= 1'b1;
      else if (clr_sticky)      sat <= 1'b0;

      if (drop_hit) begin
        if (clr_sticky)                 drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (clr_sticky) begin
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spike_somatic_aggregator.sv
// Directed bench: table-driven snapshot vectors plus hand sequences for the
// window timer, back-pressure overrun, drops, saturation and mid-stream reset.
module tb_spike_somatic_aggregator;
  import kf_pkg::*;

  localparam int OUT_W = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              eject_valid, eject_ready, m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic              enable, snap_req, clr_sticky, busy, overrun, sat;
  spike_flit_t       eject_flit;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [31:0]       window_cycles;
  logic [15:0]       gain, drop_count;

  logic              b_valid, b_ready, b_tvalid, b_tready, b_tlast, b_snap, b_clr, b_busy, b_overrun, b_sat;
  spike_flit_t       b_flit;
  logic [OUT_W-1:0]  b_tdata;
  logic [31:0]       b_window;
  logic [15:0]       b_gain, b_drop;

  spike_somatic_aggregator #(
    .MESH_WIDTH(4), .MESH_HEIGHT(4), .COUNT_W(16), .OUT_W(OUT_W), .WINDOW_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .eject_valid(eject_valid), .eject_ready(eject_ready),
    .eject_flit(eject_flit), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .enable(enable),
    .window_cycles(window_cycles), .snap_req(snap_req), .gain(gain), .clr_sticky(clr_sticky),
    .busy(busy), .overrun(overrun), .sat(sat), .drop_count(drop_count)
  );

  spike_somatic_aggregator #(
    .MESH_WIDTH(3), .MESH_HEIGHT(3), .COUNT_W(4), .OUT_W(OUT_W), .WINDOW_W(32)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .eject_valid(b_valid), .eject_ready(b_ready),
    .eject_flit(b_flit), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .enable(enable),
    .window_cycles(b_window), .snap_req(b_snap), .gain(b_gain), .clr_sticky(b_clr),
    .busy(b_busy), .overrun(b_overrun), .sat(b_sat), .drop_count(b_drop)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [OUT_W-1:0] cap_data [4];
  logic             cap_last [4];
  int               cap_n;

  typedef struct {
    int          x1, y1, n1, r1;
    logic [31:0] e1;
    int          x2, y2, n2, r2;
    logic [31:0] e2;
    logic [15:0] g;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_flits(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eject_valid = 1'b1;
      eject_flit  = '{dest_y: 4'(y), dest_x: 4'(x)};
    end
    @(negedge clk);
    eject_valid = 1'b0;
  endtask

  task automatic snap();
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  // Captures beats until tlast, starting at the current negedge.
  task automatic collect_a(input int max_cycles);
    bit done;
    done  = 1'b0;
    cap_n = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data[cap_n] = m_axis_tdata;
        cap_last[cap_n] = m_axis_tlast;
        if (m_axis_tlast || cap_n == 3) done = 1'b1;
        cap_n++;
      end
      if (!done) @(negedge clk);
    end
    chk("stream_complete", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] reg_a(input int r);
    logic [OUT_W-1:0] d;
    d = cap_data[r / 8];
    return d[(r % 8) * 32 +: 32];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] first_beat, capb [4];
    logic             capb_last [4];
    int               capb_n, nr, rise_at [4];
    logic [31:0]      r5_at [4];
    logic [31:0]      exp_v;
    bit               stable, bdone, prev, extra;

    rst_n = 1'b0; eject_valid = 1'b0; eject_flit = '0; m_axis_tready = 1'b1;
    enable = 1'b1; window_cycles = '0; snap_req = 1'b0; gain = 16'h0100; clr_sticky = 1'b0;
    b_valid = 1'b0; b_flit = '0; b_tready = 1'b1; b_window = '0; b_snap = 1'b0;
    b_gain = 16'hFFFF; b_clr = 1'b0;

    vecs[0] = '{1, 2, 5,  9, 32'd5,   3, 3, 3, 15, 32'd3, 16'h0100};
    vecs[1] = '{0, 0, 7,  0, 32'd3,   0, 0, 0,  0, 32'd0, 16'h0080};
    vecs[2] = '{2, 1, 6,  6, 32'd9,   0, 0, 0,  0, 32'd0, 16'h0180};
    vecs[3] = '{3, 0, 1,  3, 32'd255, 0, 0, 0,  0, 32'd0, 16'hFFFF};
    vecs[4] = '{0, 3, 4, 12, 32'd0,   0, 0, 0,  0, 32'd0, 16'h0000};
    vecs[5] = '{2, 3, 9, 14, 32'd18,  1, 0, 2,  1, 32'd4, 16'h0200};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(|m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("eject_ready", 64'(eject_ready), 64'd1);
    chk("rst_b_tvalid", 64'(b_tvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven snapshots of the 4x4 mesh, two 8-lane beats each.
    for (int i = 0; i < 6; i++) begin
      gain = vecs[i].g;
      send_flits(vecs[i].x1, vecs[i].y1, vecs[i].n1);
      if (vecs[i].n2 > 0) send_flits(vecs[i].x2, vecs[i].y2, vecs[i].n2);
      snap();
      collect_a(20);
      chk($sformatf("vec%0d_beats", i), 64'(cap_n), 64'd2);
      chk($sformatf("vec%0d_last0", i), 64'(cap_last[0]), 64'd0);
      chk($sformatf("vec%0d_last1", i), 64'(cap_last[1]), 64'd1);
      for (int r = 0; r < 16; r++) begin
        if (r == vecs[i].r1)                         exp_v = vecs[i].e1;
        else if (vecs[i].n2 > 0 && r == vecs[i].r2)  exp_v = vecs[i].e2;
        else                                         exp_v = 32'd0;
        chk($sformatf("vec%0d_region%0d", i, r), 64'(reg_a(r)), 64'(exp_v));
      end
    end

    // Back-pressure: beat 0 must hold, a second request only flags overrun.
    gain = 16'h0100;
    send_flits(0, 0, 2);
    m_axis_tready = 1'b0;
    snap();
    chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
    first_beat = m_axis_tdata;
    stable = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      snap_req = (c == 10);
      if (!m_axis_tvalid || m_axis_tdata !== first_beat) stable = 1'b0;
    end
    snap_req = 1'b0;
    chk("bp_beat0_stable", 64'(stable), 64'd1);
    chk("bp_region0", 64'(first_beat[31:0]), 64'd2);
    chk("bp_overrun", 64'(overrun), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    m_axis_tready = 1'b1;
    collect_a(20);
    chk("bp_beats", 64'(cap_n), 64'd2);
    extra = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) extra = 1'b1;
    end
    chk("bp_no_extra_stream", 64'(extra), 64'd0);
    @(negedge clk) clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    chk("bp_overrun_cleared", 64'(overrun), 64'd0);

    // Window timer: period 100, flit on the swap cycle goes to the next window.
    @(negedge clk);
    window_cycles = 32'd100;
    nr = 0;
    prev = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (i == 99) begin
        eject_valid = 1'b1;
        eject_flit  = '{dest_y: 4'd1, dest_x: 4'd1};
      end
      if (i == 100) eject_valid = 1'b0;
      if (m_axis_tvalid && !prev && nr < 4) begin
        rise_at[nr] = i;
        r5_at[nr]   = m_axis_tdata[5*32 +: 32];
        nr++;
      end
      prev = m_axis_tvalid;
    end
    window_cycles = '0;
    chk("win_streams", 64'(nr), 64'd2);
    chk("win_rise0", 64'(rise_at[0]), 64'd100);
    chk("win_rise1", 64'(rise_at[1]), 64'd200);
    chk("win_swapflit_w0", 64'(r5_at[0]), 64'd0);
    chk("win_swapflit_w1", 64'(r5_at[1]), 64'd1);

    // Out-of-range flits drop; disabled flits are neither counted nor dropped.
    send_flits(5, 0, 1);
    chk("drop_one", 64'(drop_count), 64'd1);
    @(negedge clk) enable = 1'b0;
    send_flits(1, 1, 1);
    send_flits(6, 0, 1);
    chk("drop_disabled", 64'(drop_count), 64'd1);
    @(negedge clk) clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    chk("drop_cleared", 64'(drop_count), 64'd0);
    snap();
    collect_a(20);
    chk("disabled_snap_beats", 64'(cap_n), 64'd2);
    chk("drop_not_counted", 64'(|(cap_data[0] | cap_data[1])), 64'd0);
    @(negedge clk) enable = 1'b1;

    // 3x3 mesh, 4-bit counters: saturation and padding lane in beat 1.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_flit  = (i < 20) ? '{dest_y: 4'd1, dest_x: 4'd1} : '{dest_y: 4'd2, dest_x: 4'd2};
    end
    @(negedge clk);
    b_valid = 1'b0;
    chk("b_sat", 64'(b_sat), 64'd1);
    @(negedge clk) b_snap = 1'b1;
    @(negedge clk) b_snap = 1'b0;
    bdone = 1'b0;
    capb_n = 0;
    for (int c = 0; c < 20 && !bdone; c++) begin
      if (b_tvalid) begin
        capb[capb_n]      = b_tdata;
        capb_last[capb_n] = b_tlast;
        if (b_tlast || capb_n == 3) bdone = 1'b1;
        capb_n++;
      end
      if (!bdone) @(negedge clk);
    end
    chk("b_beats", 64'(capb_n), 64'd2);
    chk("b_last0", 64'(capb_last[0]), 64'd0);
    chk("b_last1", 64'(capb_last[1]), 64'd1);
    chk("b_region4_sat_scaled", 64'(capb[0][4*32 +: 32]), 64'd3839);
    chk("b_region7", 64'(capb[0][7*32 +: 32]), 64'd0);
    chk("b_region8", 64'(capb[1][0 +: 32]), 64'd511);
    chk("b_beat1_lane1_pad", 64'(capb[1][1*32 +: 32]), 64'd0);

    // Asynchronous reset during beat 1 aborts the stream and empties both banks.
    gain = 16'h0100;
    send_flits(2, 2, 3);
    snap();
    eject_valid = 1'b1;
    eject_flit  = '{dest_y: 4'd1, dest_x: 4'd0};
    @(negedge clk);
    eject_valid = 1'b0;
    chk("rst_mid_on_beat1", 64'(m_axis_tlast), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    collect_a(20);
    chk("rst_mid_beats", 64'(cap_n), 64'd2);
    chk("rst_mid_all_zero", 64'(|(cap_data[0] | cap_data[1])), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
